// File: rtl/inv_columnmix_iter.sv
// inv_columnmix_iter
//   Iterative AES InvMixColumns engine. It takes one 128-bit state over a
//   valid/ready handshake and transforms COLS_PER_CYCLE columns per clock,
//   working in place in a single state register. The result is held until
//   the consumer accepts it.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for a block; in_ready high
//   RUN   | transforming columns col .. col+COLS_PER_CYCLE-1 per edge
//   DONE  | result valid on data_out; waiting for out_ready
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   data_in holds a valid state
//   in_ready   engine can accept (IDLE only)
//   data_in    input state, column c = [127-32c -: 32], byte r = [31-8r -: 8]
//   out_valid  data_out holds a finished result (DONE only)
//   out_ready  consumer accepts data_out
//   data_out   state register, same byte layout
//   busy       high in RUN or DONE
module inv_columnmix_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_col;
  logic [127:0] r_data;
  logic [127:0] w_data_run;
  logic         w_last;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 0e/0b/0d/09 multiplies share one x2/x4/x8 chain per byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] s  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      s[r]  = c[31-8*r -: 8];
      x2    = xtime(s[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ s[r];
      mb[r] = x8 ^ x2 ^ s[r];
      md[r] = x8 ^ x4 ^ s[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    inv_mix_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                   m9[0] ^ me[1] ^ mb[2] ^ md[3],
                   md[0] ^ m9[1] ^ me[2] ^ mb[3],
                   mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [6:0] col_msb(input logic [1:0] c);
    col_msb = 7'd127 - {c, 5'b0};
  endfunction

  // Columns handled per edge: col .. col+COLS_PER_CYCLE-1. col only ever
  // advances in steps of COLS_PER_CYCLE from 0, so this never wraps.
  always_comb begin
    w_data_run = r_data;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      w_data_run[col_msb(r_col + 2'(k)) -: 32] =
        inv_mix_col(r_data[col_msb(r_col + 2'(k)) -: 32]);
    end
  end

  assign w_last = (r_col == 2'(4 - COLS_PER_CYCLE));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)   w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state == S_RUN) || (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= 2'd0;
      r_data <= 128'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data <= data_in;
            r_col  <= 2'd0;
          end
        end
        S_RUN: begin
          r_data <= w_data_run;
          r_col  <= r_col + 2'(COLS_PER_CYCLE);
        end
        default: ;
      endcase
    end
  end

  assign data_out = r_data;

endmodule

// File: tb/tb_inv_columnmix_iter.sv
module tb_inv_columnmix_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         iv   [3];
  logic         ir   [3];
  logic [127:0] di   [3];
  logic         ov   [3];
  logic         orr  [3];
  logic [127:0] dout [3];
  logic         bsy  [3];

  int errors = 0;
  int checks = 0;
  int hs0 = 0;
  int exp_hs0 = 0;

  always #5 clk = ~clk;

  inv_columnmix_iter #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .data_in(di[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .data_out(dout[0]), .busy(bsy[0]));
  inv_columnmix_iter #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .data_in(di[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .data_out(dout[1]), .busy(bsy[1]));
  inv_columnmix_iter #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .data_in(di[2]),
    .out_valid(ov[2]), .out_ready(orr[2]), .data_out(dout[2]), .busy(bsy[2]));

  // completed handshakes on the COLS_PER_CYCLE=1 instance
  always @(posedge clk) if (!rst && ov[0] === 1'b1 && orr[0] === 1'b1) hs0++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] x2(input logic [7:0] b);
    x2 = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // forward MixColumns on all four columns
  function automatic logic [127:0] fwd_mix(input logic [127:0] st);
    logic [7:0] s0, s1, s2, s3;
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      s0 = st[127-32*c -: 8];
      s1 = st[119-32*c -: 8];
      s2 = st[111-32*c -: 8];
      s3 = st[103-32*c -: 8];
      o[127-32*c -: 32] = {x2(s0) ^ x2(s1) ^ s1 ^ s2 ^ s3,
                           s0 ^ x2(s1) ^ x2(s2) ^ s2 ^ s3,
                           s0 ^ s1 ^ x2(s2) ^ x2(s3) ^ s3,
                           x2(s0) ^ s0 ^ s1 ^ s2 ^ x2(s3)};
    end
    fwd_mix = o;
  endfunction

  // accept one block on instance d with out_ready held high; check latency/result
  task automatic run_block(input int d, input logic [127:0] din, input logic [127:0] exp,
                           input int lat_exp, input string tag);
    int lat;
    orr[d] = 1'b1;
    di[d]  = din;
    iv[d]  = 1'b1;
    tick;
    iv[d] = 1'b0;
    chk({tag, "_busy"}, 128'(bsy[d]), 128'd1);
    chk({tag, "_inrdy_low"}, 128'(ir[d]), 128'd0);
    lat = 0;
    while (ov[d] !== 1'b1 && lat < 20) begin
      tick;
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(lat_exp));
    chk({tag, "_data"}, dout[d], exp);
    if (d == 0) exp_hs0++;
    tick;
    chk({tag, "_retired_ov"}, 128'(ov[d]), 128'd0);
    chk({tag, "_retired_inrdy"}, 128'(ir[d]), 128'd1);
    orr[d] = 1'b0;
  endtask

  localparam logic [127:0] FIPS_IN  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] KN_IN    = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] KN_OUT   = 128'hdb135345_f20a225c_01010101_d4d4d4d5;

  initial begin
    logic [127:0] plain, din;
    int t, seen;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; orr[d] = 1'b0; di[d] = '0;
    end
    tick;
    tick;
    rst = 1'b0;

    for (int d = 0; d < 3; d++) begin
      chk("rst_inrdy", 128'(ir[d]), 128'd1);
      chk("rst_ov", 128'(ov[d]), 128'd0);
      chk("rst_busy", 128'(bsy[d]), 128'd0);
      chk("rst_dout", dout[d], 128'd0);
    end

    run_block(0, FIPS_IN, FIPS_OUT, 4, "fips_c1");
    run_block(0, KN_IN, KN_OUT, 4, "known_c1");
    run_block(1, KN_IN, KN_OUT, 2, "known_c2");
    run_block(2, KN_IN, KN_OUT, 1, "known_c4");
    run_block(2, FIPS_IN, FIPS_OUT, 1, "fips_c4");

    // backpressure on the single-column instance
    di[0] = KN_IN; iv[0] = 1'b1; orr[0] = 1'b0;
    tick;
    iv[0] = 1'b0;
    t = 0;
    while (ov[0] !== 1'b1 && t < 20) begin tick; t++; end
    chk("bp_ov_rise", 128'(ov[0]), 128'd1);
    di[0] = FIPS_IN; iv[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_hold_data", dout[0], KN_OUT);
      chk("bp_hold_inrdy", 128'(ir[0]), 128'd0);
    end
    chk("bp_hold_ov", 128'(ov[0]), 128'd1);
    iv[0] = 1'b0; orr[0] = 1'b1;
    exp_hs0++;
    tick;
    orr[0] = 1'b0;
    chk("bp_after_inrdy", 128'(ir[0]), 128'd1);
    chk("bp_after_ov", 128'(ov[0]), 128'd0);
    chk("bp_after_data", dout[0], KN_OUT);

    // reset one edge after acceptance
    di[0] = FIPS_IN; iv[0] = 1'b1; orr[0] = 1'b1;
    tick;
    iv[0] = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_inrdy", 128'(ir[0]), 128'd1);
    chk("mrst_ov", 128'(ov[0]), 128'd0);
    chk("mrst_busy", 128'(bsy[0]), 128'd0);
    chk("mrst_dout", dout[0], 128'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (ov[0] === 1'b1) seen++;
    end
    chk("mrst_no_completion", 128'(seen), 128'd0);
    orr[0] = 1'b0;

    // streaming round trip with random gaps
    for (int n = 0; n < 1000; n++) begin
      plain = {$urandom, $urandom, $urandom, $urandom};
      din   = fwd_mix(plain);
      for (int g = $urandom_range(0, 3); g > 0; g--) tick;
      t = 0;
      while (ir[0] !== 1'b1 && t < 20) begin tick; t++; end
      di[0] = din; iv[0] = 1'b1;
      tick;
      iv[0] = 1'b0;
      t = 0;
      while (ov[0] !== 1'b1 && t < 20) begin tick; t++; end
      chk("stream_ov", 128'(ov[0]), 128'd1);
      for (int g = $urandom_range(0, 3); g > 0; g--) tick;
      chk("stream_data", dout[0], plain);
      orr[0] = 1'b1;
      exp_hs0++;
      tick;
      orr[0] = 1'b0;
    end
    tick;
    chk("handshake_count", 128'(hs0), 128'(exp_hs0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inv_columnmix_iter.md
# inv_columnmix_iter

Iterative AES InvMixColumns engine for the decryption datapath, the inverse of the combinational forward column-mix stage. It accepts one 128-bit state over a valid/ready handshake. It transforms COLS_PER_CYCLE columns per clock in a single in-place state register, then holds the result until the consumer takes it. Area is traded for latency: only COLS_PER_CYCLE column multipliers are instantiated instead of four.

## Interface
- COLS_PER_CYCLE, 1: columns transformed per RUN cycle.
  - Legal values: 1, 2, 4.
  - N = 4/COLS_PER_CYCLE RUN cycles per block.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  data_in holds a valid state.
- in_ready  out  1  engine can accept; high only in IDLE.
- data_in  in  128  input state. Column c = bits [127-32c -: 32]. Byte r of a column = bits [31-8r -: 8] within it, so s0 is the MSB byte.
- out_valid  out  1  data_out holds a finished result; high only in DONE.
- out_ready  in  1  consumer accepts data_out.
- data_out  out  128  result, same byte layout; driven directly from the state register.
- busy  out  1  high in RUN or DONE.

## Operation
- Per column (s0..s3), with GF(2^8) polynomial x^8+x^4+x^3+x+1 (0x11B):
  - o0 = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3
  - o1 = 0e·s1 ^ 0b·s2 ^ 0d·s3 ^ 09·s0
  - o2 = 0e·s2 ^ 0b·s3 ^ 0d·s0 ^ 09·s1
  - o3 = 0e·s3 ^ 0b·s0 ^ 0d·s1 ^ 09·s2
- Multiplies are built from xtime chains (x2, x4, x8) and XORs. No lookup tables and no carries; every intermediate value is 8 bits.
- FSM states: IDLE, RUN, DONE. A 2-bit column pointer `col` tracks progress.
- IDLE → RUN when in_valid && in_ready.
  - On that edge: state register ← data_in, col ← 0.
- RUN: each edge replaces columns col .. col+COLS_PER_CYCLE-1 in place, then col += COLS_PER_CYCLE (mod 4).
  - Columns are processed in order 0→3.
  - The edge that processes column 3 moves to DONE.
  - Inputs are ignored in RUN; in_ready = 0.
- DONE → IDLE when out_ready is high.
  - The state register holds its value; data_out stays stable until the handshake completes.
- in_valid is not examined outside IDLE. A new block cannot be accepted on the same edge that DONE retires a block; in_ready rises one cycle later.
- Partially transformed values appear on data_out during RUN. Consumers must qualify data_out with out_valid.

## Timing
- Reset (rst high at an edge) sets: state = IDLE, col = 0, state register = 0.
  - Resulting outputs: in_ready = 1, out_valid = 0, busy = 0, data_out = 0.
- Reset in RUN or DONE aborts the block and discards it. No out_valid pulse is produced for it.
- Reset has priority over every handshake on the same edge.
- Latency: block accepted on edge E; out_valid is high in the cycle after edge E+N.
  - COLS_PER_CYCLE = 1: N = 4.
  - COLS_PER_CYCLE = 4: N = 1.
- Back-to-back throughput with out_ready held high: one block per N+2 cycles.
- Backpressure: out_valid stays high and data_out is frozen for any number of cycles with out_ready low.
- out_ready high while not in DONE has no effect.

## Test plan
- FIPS-197 round-1 column set.
  - data_in = 046681e5_e0cb199a_48f8d37a_2806264c.
  - Required: data_out = d4bf5d30_e0b452ae_b84111f1_1e2798e5, with out_valid first high in the cycle after edge E+4 (COLS_PER_CYCLE = 1).
- Known columns.
  - data_in = 8e4da1bc_9fdc589d_01010101_d5d5d7d6.
  - Required: data_out = db135345_f20a225c_01010101_d4d4d4d5.
  - Run for every COLS_PER_CYCLE value (1, 2, 4); latency must be 4, 2, 1 respectively.
- Backpressure.
  - Hold out_ready low for 10 cycles after out_valid rises.
  - Required: data_out is unchanged, in_ready = 0, and a new in_valid is ignored.
  - Then pulse out_ready: the next cycle has in_ready = 1 and out_valid = 0.
- Mid-operation reset.
  - Assert rst at the edge after acceptance (RUN, col = 1).
  - Required: next cycle shows in_ready = 1, out_valid = 0, busy = 0, data_out = 0.
  - Required: no completion is ever reported for the aborted block.
- Streaming round-trip.
  - Drive 1000 random states through a forward column-mix model, then this block, with random in_valid/out_ready gaps.
  - Required: every output equals its original input, in order, with no drops or duplicates.
